snn_lif_accum: RTL and testbench

Leaky-free integrate-and-fire stage directly downstream of the ADC mux in the SNN core. Per bit-plane it takes the 20 ADC codes (Scheme B: 10 positive + 10 negative BL), forms 10 signed differences, weights each by its bit-plane significance (MSB→LSB), and accumulates into 10 signed membrane potentials. After the last plane of a timestep it compares every membrane against the threshold and emits a spike vector toward the output FIFO.

---
 rtl/snn_soc_pkg.sv | 31 +++
 rtl/snn_sat_add.sv | 28 ++
 rtl/snn_lif_accum.sv | 114 +++++++++++
 tb/tb_snn_lif_accum.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_soc_pkg.sv
// Shared types and constants for the SNN core.
// Covers the integrate-and-fire stage: membrane type, FSM states and the per-plane term.
package snn_soc_pkg;

    localparam int NUM_OUTPUTS   = 10;
    localparam int ADC_BITS      = 8;
    localparam int PIXEL_BITS    = 8;
    localparam int LIF_MEM_WIDTH = 32;
    localparam int LIF_BIT_IDX_W = $clog2(PIXEL_BITS);
    localparam int LIF_IDX_W     = $clog2(NUM_OUTPUTS);

    typedef logic signed [LIF_MEM_WIDTH-1:0] lif_mem_t;

    localparam lif_mem_t LIF_MEM_MAX       = {1'b0, {(LIF_MEM_WIDTH-1){1'b1}}};
    localparam lif_mem_t LIF_MEM_MIN       = {1'b1, {(LIF_MEM_WIDTH-1){1'b0}}};
    localparam lif_mem_t THRESHOLD_DEFAULT = LIF_MEM_WIDTH'(26010);

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE, OUT} lif_state_e;

    // Signed bit-plane contribution: (pos - neg) weighted by the plane's significance.
    function automatic lif_mem_t plane_term(input logic [ADC_BITS-1:0]      pos,
                                            input logic [ADC_BITS-1:0]      neg,
                                            input logic [LIF_BIT_IDX_W-1:0] bit_idx);
        logic signed [ADC_BITS:0] diff;
        lif_mem_t                 diff_ext;
        diff     = $signed({1'b0, pos}) - $signed({1'b0, neg});
        diff_ext = {{(LIF_MEM_WIDTH-ADC_BITS-1){diff[ADC_BITS]}}, diff};
        return diff_ext <<< bit_idx;
    endfunction

endpackage

// File: rtl/snn_sat_add.sv
// Signed add/subtract that clamps to the membrane range instead of wrapping.
module snn_sat_add
    import snn_soc_pkg::*;
(
    input  lif_mem_t i_a,
    input  lif_mem_t i_b,
    input  logic     i_sub,
    output lif_mem_t o_sum
);

    // One guard bit holds any sum or difference of two in-range operands exactly.
    logic [LIF_MEM_WIDTH:0] w_a_ext;
    logic [LIF_MEM_WIDTH:0] w_b_ext;
    logic [LIF_MEM_WIDTH:0] w_full;

    assign w_a_ext = {i_a[LIF_MEM_WIDTH-1], i_a};
    assign w_b_ext = i_sub ? -{i_b[LIF_MEM_WIDTH-1], i_b} : {i_b[LIF_MEM_WIDTH-1], i_b};
    assign w_full  = w_a_ext + w_b_ext;

    // NOTE: every path assigns o_sum, so this always_comb cannot infer a latch.
    always_comb begin
        o_sum = w_full[LIF_MEM_WIDTH-1:0];
        if (w_full[LIF_MEM_WIDTH] != w_full[LIF_MEM_WIDTH-1]) begin
            o_sum = w_full[LIF_MEM_WIDTH] ? LIF_MEM_MIN : LIF_MEM_MAX;
        end
    end

endmodule

// File: rtl/snn_lif_accum.sv
// Integrate-and-fire stage: accumulates weighted ADC differences per bit-plane
// into signed membranes and fires against a threshold after the last plane.
module snn_lif_accum
    import snn_soc_pkg::*;
(
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_frame_start,
    input  lif_mem_t                            i_threshold,
    input  logic                                i_reset_mode,
    input  logic                                i_adc_valid,
    output logic                                o_adc_ready,
    input  logic [2*NUM_OUTPUTS*ADC_BITS-1:0]   i_adc_data,
    input  logic [LIF_BIT_IDX_W-1:0]            i_bit_idx,
    input  logic                                i_plane_last,
    output logic                                o_spike_valid,
    input  logic                                i_spike_ready,
    output logic [NUM_OUTPUTS-1:0]              o_spike_vec,
    output logic                                o_busy
);

    lif_state_e                        r_state;
    logic [LIF_IDX_W-1:0]              r_idx;
    logic [2*NUM_OUTPUTS*ADC_BITS-1:0] r_data;
    logic [LIF_BIT_IDX_W-1:0]          r_bit_idx;
    logic                              r_last;
    lif_mem_t                          r_mem [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0]            r_spike_vec;
    logic                              r_spike_valid;

    lif_mem_t                          w_term    [NUM_OUTPUTS];
    lif_mem_t                          w_operand [NUM_OUTPUTS];
    lif_mem_t                          w_sum     [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0]            w_fire;
    logic                              w_in_fire;

    assign w_in_fire = (r_state == FIRE);

    // Each neuron's adder adds its plane term in ACCUM and subtracts the threshold in FIRE.
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_neuron
        assign w_term[k]    = plane_term(r_data[k*ADC_BITS +: ADC_BITS],
                                         r_data[(k+NUM_OUTPUTS)*ADC_BITS +: ADC_BITS],
                                         r_bit_idx);
        assign w_operand[k] = w_in_fire ? i_threshold : w_term[k];
        assign w_fire[k]    = (r_mem[k] >= i_threshold);

        snn_sat_add u_sat_add (
            .i_a   (r_mem[k]),
            .i_b   (w_operand[k]),
            .i_sub (w_in_fire),
            .o_sum (w_sum[k])
        );
    end

    assign o_adc_ready   = (r_state == IDLE) && !i_rst;
    assign o_busy        = (r_state != IDLE);
    assign o_spike_valid = r_spike_valid;
    assign o_spike_vec   = r_spike_vec;

    // NOTE: the membranes are a handful of registers, not a RAM, so they are cleared in reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_data        <= '0;
            r_bit_idx     <= '0;
            r_last        <= 1'b0;
            r_spike_vec   <= '0;
            r_spike_valid <= 1'b0;
            for (int k = 0; k < NUM_OUTPUTS; k++) r_mem[k] <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_frame_start) begin
                        for (int k = 0; k < NUM_OUTPUTS; k++) r_mem[k] <= '0;
                    end
                    if (i_adc_valid) begin
                        r_data    <= i_adc_data;
                        r_bit_idx <= i_bit_idx;
                        r_last    <= i_plane_last;
                        r_idx     <= '0;
                        r_state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    for (int k = 0; k < NUM_OUTPUTS; k++) begin
                        if (r_idx == LIF_IDX_W'(k)) r_mem[k] <= w_sum[k];
                    end
                    if (r_idx == LIF_IDX_W'(NUM_OUTPUTS-1)) begin
                        r_state <= r_last ? FIRE : IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                FIRE: begin
                    for (int k = 0; k < NUM_OUTPUTS; k++) begin
                        if (w_fire[k]) r_mem[k] <= i_reset_mode ? w_sum[k] : '0;
                    end
                    r_spike_vec   <= w_fire;
                    r_spike_valid <= 1'b1;
                    r_state       <= OUT;
                end
                OUT: begin
                    if (i_spike_ready) begin
                        r_spike_valid <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_lif_accum.sv
// Randomized and directed bench for snn_lif_accum with a scoreboard fed by a
// plain-arithmetic membrane model and drained by an independent spike monitor.
module tb_snn_lif_accum;
    import snn_soc_pkg::*;

    logic                              clk = 1'b0;
    logic                              i_rst;
    logic                              i_frame_start;
    lif_mem_t                          i_threshold;
    logic                              i_reset_mode;
    logic                              i_adc_valid;
    logic                              o_adc_ready;
    logic [2*NUM_OUTPUTS*ADC_BITS-1:0] i_adc_data;
    logic [LIF_BIT_IDX_W-1:0]          i_bit_idx;
    logic                              i_plane_last;
    logic                              o_spike_valid;
    logic                              i_spike_ready;
    logic [NUM_OUTPUTS-1:0]            o_spike_vec;
    logic                              o_busy;

    always #5 clk = ~clk;

    snn_lif_accum dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_frame_start (i_frame_start),
        .i_threshold   (i_threshold),
        .i_reset_mode  (i_reset_mode),
        .i_adc_valid   (i_adc_valid),
        .o_adc_ready   (o_adc_ready),
        .i_adc_data    (i_adc_data),
        .i_bit_idx     (i_bit_idx),
        .i_plane_last  (i_plane_last),
        .o_spike_valid (o_spike_valid),
        .i_spike_ready (i_spike_ready),
        .o_spike_vec   (o_spike_vec),
        .o_busy        (o_busy)
    );

    typedef struct packed {
        logic [NUM_OUTPUTS-1:0]               vec;
        logic [NUM_OUTPUTS*LIF_MEM_WIDTH-1:0] mems;
    } exp_t;

    int     errors = 0;
    int     checks = 0;
    int     tb_pos [NUM_OUTPUTS];
    int     tb_neg [NUM_OUTPUTS];
    longint model_mem [NUM_OUTPUTS];
    exp_t   exp_q [$];
    bit     force_en  = 1'b1;
    bit     force_val = 1'b1;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic void zero_data();
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            tb_pos[i] = 0;
            tb_neg[i] = 0;
        end
    endfunction

    function automatic void zero_model();
        for (int i = 0; i < NUM_OUTPUTS; i++) model_mem[i] = 0;
    endfunction

    function automatic void model_plane(input int bit_idx);
        for (int i = 0; i < NUM_OUTPUTS; i++)
            model_mem[i] = clamp(model_mem[i] + longint'(tb_pos[i] - tb_neg[i]) * (64'sd1 << bit_idx));
    endfunction

    function automatic void model_fire(input longint thr, input bit mode);
        exp_t e;
        e = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (model_mem[i] >= thr) begin
                e.vec[i]     = 1'b1;
                model_mem[i] = mode ? clamp(model_mem[i] - thr) : 0;
            end
            e.mems[i*LIF_MEM_WIDTH +: LIF_MEM_WIDTH] = model_mem[i][LIF_MEM_WIDTH-1:0];
        end
        exp_q.push_back(e);
    endfunction

    task automatic check_mems(input string name);
        for (int i = 0; i < NUM_OUTPUTS; i++)
            check(longint'(dut.r_mem[i]) == model_mem[i], name,
                  $sformatf("mem[%0d] got %0d want %0d", i, dut.r_mem[i], model_mem[i]));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!o_adc_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!o_adc_ready) check(1'b0, "ready_timeout", "adc_ready never rose within 300 cycles");
    endtask

    task automatic drive_plane(input int bit_idx, input bit last, input bit fs);
        wait_ready();
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            i_adc_data[k*ADC_BITS +: ADC_BITS]               = ADC_BITS'(tb_pos[k]);
            i_adc_data[(k+NUM_OUTPUTS)*ADC_BITS +: ADC_BITS] = ADC_BITS'(tb_neg[k]);
        end
        i_bit_idx     = LIF_BIT_IDX_W'(bit_idx);
        i_plane_last  = last;
        i_frame_start = fs;
        i_adc_valid   = 1'b1;
        @(posedge clk);
        #1;
        i_adc_valid   = 1'b0;
        i_frame_start = 1'b0;
        i_plane_last  = 1'b0;
    endtask

    // Model first, then drive; latency is counted in falling edges after acceptance.
    task automatic plane(input int bit_idx, input bit last, input bit fs);
        int n;
        if (fs) zero_model();
        model_plane(bit_idx);
        if (last) model_fire(longint'(i_threshold), i_reset_mode);
        drive_plane(bit_idx, last, fs);
        n = 0;
        if (last) begin
            do begin @(negedge clk); n++; end while (!o_spike_valid && n < 100);
            check(n == 12, "spike_latency", $sformatf("got %0d cycles want 12", n));
        end else begin
            do begin @(negedge clk); n++; end while (!o_adc_ready && n < 100);
            check(n == 11, "ready_latency", $sformatf("got %0d cycles want 11", n));
        end
    endtask

    task automatic clear_frame();
        wait_ready();
        i_frame_start = 1'b1;
        @(posedge clk);
        #1;
        i_frame_start = 1'b0;
        zero_model();
    endtask

    always @(posedge clk) begin
        #1;
        i_spike_ready = force_en ? force_val : ($urandom_range(0, 2) != 0);
    end

    bit                     hold_pending = 1'b0;
    logic [NUM_OUTPUTS-1:0] hold_vec;

    always @(negedge clk) begin
        if (i_rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending)
                check(o_spike_valid === 1'b1 && o_spike_vec === hold_vec, "spike_hold",
                      $sformatf("valid=%0b vec=%b want valid=1 vec=%b", o_spike_valid, o_spike_vec, hold_vec));
            hold_pending = 1'b0;
            if (o_spike_valid) begin
                check(o_adc_ready == 1'b0 && o_busy == 1'b1, "out_flags",
                      $sformatf("adc_ready=%0b busy=%0b want 0/1", o_adc_ready, o_busy));
                if (i_spike_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_spike", $sformatf("vec=%b with empty scoreboard", o_spike_vec));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check(o_spike_vec == e.vec, "spike_vec",
                              $sformatf("got %b want %b", o_spike_vec, e.vec));
                        for (int i = 0; i < NUM_OUTPUTS; i++)
                            check(dut.r_mem[i] == e.mems[i*LIF_MEM_WIDTH +: LIF_MEM_WIDTH], "fire_mem",
                                  $sformatf("mem[%0d] got %0d want %0d", i, dut.r_mem[i],
                                            $signed(e.mems[i*LIF_MEM_WIDTH +: LIF_MEM_WIDTH])));
                    end
                end else begin
                    hold_pending = 1'b1;
                    hold_vec     = o_spike_vec;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_rst         = 1'b1;
        i_frame_start = 1'b0;
        i_threshold   = THRESHOLD_DEFAULT;
        i_reset_mode  = 1'b0;
        i_adc_valid   = 1'b0;
        i_adc_data    = '0;
        i_bit_idx     = '0;
        i_plane_last  = 1'b0;
        zero_data();
        zero_model();

        repeat (3) @(negedge clk);
        check(o_adc_ready == 1'b0, "reset_ready", $sformatf("got %0b want 0", o_adc_ready));
        check(o_spike_valid == 1'b0 && o_busy == 1'b0 && o_spike_vec == '0, "reset_outputs",
              $sformatf("valid=%0b busy=%0b vec=%b want 0/0/0", o_spike_valid, o_busy, o_spike_vec));
        i_rst = 1'b0;
        @(negedge clk);
        check(o_adc_ready == 1'b1, "release_ready", $sformatf("got %0b want 1", o_adc_ready));
        check_mems("reset_mem");

        // Single MSB plane below threshold.
        zero_data(); tb_pos[0] = 200; tb_neg[0] = 100;
        plane(7, 1, 0);

        // Two planes crossing the threshold, in both reset modes.
        for (int mode = 0; mode < 2; mode++) begin
            i_reset_mode = mode[0];
            clear_frame();
            zero_data(); tb_pos[0] = 255;
            plane(7, 0, 0);
            plane(6, 1, 0);
        end

        // Negative membrane, then frame_start clears everything.
        clear_frame();
        zero_data(); tb_neg[1] = 255;
        plane(7, 1, 0);
        check(longint'(dut.r_mem[1]) == -64'sd32640, "neg_mem", $sformatf("got %0d want -32640", dut.r_mem[1]));
        clear_frame();
        @(negedge clk);
        check_mems("frame_clear");

        // Consumer stalls for five cycles in OUT.
        force_val = 1'b0;
        zero_data(); tb_pos[4] = 255; i_threshold = 100; i_reset_mode = 1'b0;
        plane(7, 1, 0);
        repeat (5) @(negedge clk);
        force_val = 1'b1;
        repeat (2) @(negedge clk);
        check(o_busy == 1'b0 && o_adc_ready == 1'b1 && o_spike_valid == 1'b0, "stall_release",
              $sformatf("busy=%0b ready=%0b valid=%0b want 0/1/0", o_busy, o_adc_ready, o_spike_valid));

        // Reset in the middle of ACCUM discards the partial plane.
        zero_data(); tb_pos[0] = 77; tb_pos[1] = 33;
        drive_plane(5, 1, 0);
        repeat (3) @(negedge clk);
        check(o_busy == 1'b1, "accum_busy", $sformatf("got %0b want 1", o_busy));
        i_rst = 1'b1;
        @(negedge clk);
        zero_model();
        check(o_adc_ready == 1'b0 && o_spike_valid == 1'b0 && o_busy == 1'b0, "mid_reset",
              $sformatf("ready=%0b valid=%0b busy=%0b want 0/0/0", o_adc_ready, o_spike_valid, o_busy));
        check_mems("mid_reset_mem");
        i_rst = 1'b0;
        @(negedge clk);
        check(o_adc_ready == 1'b1, "mid_reset_release", $sformatf("got %0b want 1", o_adc_ready));

        // frame_start coincident with a plane: clear first, then accumulate.
        i_threshold = LIF_MEM_MAX;
        zero_data(); tb_pos[2] = 50; tb_pos[7] = 9;
        plane(3, 0, 0);
        zero_data(); tb_pos[2] = 10;
        plane(0, 1, 1);

        // Saturation on subtract with the most negative threshold, then on add.
        clear_frame();
        i_threshold = LIF_MEM_MIN; i_reset_mode = 1'b1;
        zero_data(); tb_pos[0] = 200; tb_neg[0] = 100;
        plane(7, 1, 0);
        i_threshold = LIF_MEM_MAX;
        zero_data(); tb_pos[0] = 255;
        plane(7, 1, 0);

        // Randomized timesteps with a randomly stalling consumer.
        force_en = 1'b0;
        for (int t = 0; t < 25; t++) begin
            int np;
            i_threshold  = LIF_MEM_WIDTH'($urandom_range(0, 65000)) - LIF_MEM_WIDTH'(5000);
            i_reset_mode = 1'($urandom_range(0, 1));
            np = $urandom_range(1, PIXEL_BITS);
            for (int p = 0; p < np; p++) begin
                for (int i = 0; i < NUM_OUTPUTS; i++) begin
                    tb_pos[i] = $urandom_range(0, 255);
                    tb_neg[i] = $urandom_range(0, 255);
                end
                plane(PIXEL_BITS - 1 - p, p == np - 1, p == 0 && $urandom_range(0, 3) == 0);
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0, "drain", $sformatf("%0d spikes still outstanding", exp_q.size()));
        @(negedge clk);
        check_mems("final_mem");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
